// File: rtl/dec_brcnt_unit_if.sv
// Command / read-response bundle for the branch counter unit.
// Signals: cmd_valid, cmd_op, cmd_idx, cmd_mode (to unit); rd_valid, rd_data, rd_err (from unit).
interface dec_brcnt_unit_if #(
    parameter int IDXW      = 2,
    parameter int CNT_WIDTH = 32
);
    logic                 cmd_valid;
    logic [2:0]           cmd_op;
    logic [IDXW-1:0]      cmd_idx;
    logic [1:0]           cmd_mode;
    logic                 rd_valid;
    logic [CNT_WIDTH-1:0] rd_data;
    logic                 rd_err;

    modport master (
        output cmd_valid, cmd_op, cmd_idx, cmd_mode,
        input  rd_valid, rd_data, rd_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_idx, cmd_mode,
        output rd_valid, rd_data, rd_err
    );
endinterface

// File: rtl/dec_brcnt_unit.sv
// Branch event counters fed by two commit pipes, controlled through a command port.
// Ports: clk, rst_l, freeze, i0/i1 branch valid/taken/misp, bus (cmd/rd), running, ovf.
// Define RV_BRCNT_SAT_EN to saturate on overflow instead of wrapping.
module dec_brcnt_unit #(
    parameter int NUM_CNT   = 4,
    parameter int CNT_WIDTH = 32,
    localparam int IDXW     = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1
) (
    input  logic               clk,
    input  logic               rst_l,
    input  logic               freeze,
    input  logic               i0_br_valid,
    input  logic               i0_br_taken,
    input  logic               i0_br_misp,
    input  logic               i1_br_valid,
    input  logic               i1_br_taken,
    input  logic               i1_br_misp,
    dec_brcnt_unit_if.slave    bus,
    output logic [NUM_CNT-1:0] running,
    output logic [NUM_CNT-1:0] ovf
);

    typedef enum logic [2:0] {
        OP_NOP, OP_RESET, OP_START, OP_STOP,
        OP_READ, OP_SETMODE, OP_START_ALL, OP_STOP_ALL
    } op_e;

    typedef enum logic {IDLE, RUN} run_e;

    run_e                 st_q   [NUM_CNT];
    logic [1:0]           mode_q [NUM_CNT];
    logic [CNT_WIDTH-1:0] cnt_q  [NUM_CNT];
    logic [NUM_CNT-1:0]   ovf_q;

    logic                 rd_valid_q;
    logic [CNT_WIDTH-1:0] rd_data_q;
    logic                 rd_err_q;

    op_e                  op;
    logic                 idx_ok;
    logic [NUM_CNT-1:0]   sel;
    logic [NUM_CNT-1:0]   carry;
    logic [CNT_WIDTH-1:0] nxt    [NUM_CNT];
    logic [CNT_WIDTH-1:0] rd_cnt;

    function automatic logic hit(input logic [1:0] m, input logic v,
                                 input logic t, input logic mp);
        logic r;
        unique case (m)
            2'd0:    r = v;
            2'd1:    r = v & t;
            2'd2:    r = v & ~t;
            default: r = v & mp;
        endcase
        return r;
    endfunction

    assign op     = op_e'(bus.cmd_op);
    assign idx_ok = {{(32-IDXW){1'b0}}, bus.cmd_idx} < 32'(NUM_CNT);

    always_comb begin
        logic [1:0]         inc;
        logic [CNT_WIDTH:0] sum;
        rd_cnt = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            sel[i] = bus.cmd_valid && idx_ok && (bus.cmd_idx == IDXW'(i));
            if (bus.cmd_idx == IDXW'(i)) rd_cnt = cnt_q[i];
            // Qualify with the run state held before this cycle's command
            inc = 2'd0;
            if (st_q[i] == RUN && !freeze) begin
                inc = {1'b0, hit(mode_q[i], i0_br_valid, i0_br_taken, i0_br_misp)}
                    + {1'b0, hit(mode_q[i], i1_br_valid, i1_br_taken, i1_br_misp)};
            end
            sum      = {1'b0, cnt_q[i]} + (CNT_WIDTH+1)'(inc);
            carry[i] = sum[CNT_WIDTH];
`ifdef RV_BRCNT_SAT_EN
            nxt[i]   = sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
`else
            nxt[i]   = sum[CNT_WIDTH-1:0];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                st_q[i]   <= IDLE;
                mode_q[i] <= 2'd0;
                cnt_q[i]  <= '0;
            end
            ovf_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_err_q   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CNT; i++) begin
                if (sel[i] && op == OP_RESET) begin
                    cnt_q[i] <= '0;
                    ovf_q[i] <= 1'b0;
                end else begin
                    cnt_q[i] <= nxt[i];
                    if (carry[i]) ovf_q[i] <= 1'b1;
                end
                if ((bus.cmd_valid && op == OP_START_ALL) ||
                    (sel[i] && op == OP_START)) begin
                    st_q[i] <= RUN;
                end else if ((bus.cmd_valid && op == OP_STOP_ALL) ||
                             (sel[i] && op == OP_STOP)) begin
                    st_q[i] <= IDLE;
                end
                if (sel[i] && op == OP_SETMODE) mode_q[i] <= bus.cmd_mode;
            end
            rd_valid_q <= bus.cmd_valid && op == OP_READ;
            if (bus.cmd_valid && op == OP_READ) begin
                rd_data_q <= idx_ok ? rd_cnt : '0;
                rd_err_q  <= !idx_ok;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CNT; i++) running[i] = (st_q[i] == RUN);
    end

    assign ovf          = ovf_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_err   = rd_err_q;

endmodule
